// File: rtl/vga_pkg.sv
// vga_pkg: shared 640x480@60 raster timing constants and pixel types
// used by the sync generator and the symbol/digit renderers.
package vga_pkg;

    localparam int DEF_DIV      = 4;
    localparam int DEF_HD       = 640;
    localparam int DEF_HF       = 16;
    localparam int DEF_HR       = 96;
    localparam int DEF_HB       = 48;
    localparam int DEF_VD       = 480;
    localparam int DEF_VF       = 10;
    localparam int DEF_VR       = 2;
    localparam int DEF_VB       = 33;
    localparam int DEF_SYNC_DLY = 3;

    localparam int H_TOTAL = DEF_HD + DEF_HF + DEF_HR + DEF_HB;
    localparam int V_TOTAL = DEF_VD + DEF_VF + DEF_VR + DEF_VB;

    localparam int H_SYNC_START = DEF_HD + DEF_HF;
    localparam int H_SYNC_END   = DEF_HD + DEF_HF + DEF_HR - 1;
    localparam int V_SYNC_START = DEF_VD + DEF_VF;
    localparam int V_SYNC_END   = DEF_VD + DEF_VF + DEF_VR - 1;

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } rgb12_t;

    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mod_n_counter.sv
// mod_n_counter: enabled modulo-N counter with a wrap strobe that is
// high while enabled on the last count.
module mod_n_counter
    import vga_pkg::*;
#(
    parameter int N = 4,
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en_i,
    output logic [W-1:0] count_o,
    output logic         wrap_o
);

    localparam logic [W-1:0] LAST = W'(N - 1);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;
    logic         at_last;

    assign at_last = (cnt_q == LAST);

    // advance on enable, fold back to zero after the last count
    always_comb begin
        cnt_d = cnt_q;
        if (en_i) begin
            cnt_d = at_last ? '0 : cnt_q + 1'b1;
        end
    end

    // count register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign count_o = cnt_q;
    assign wrap_o  = en_i && at_last;

endmodule

// File: rtl/vga_sync_gen.sv
// vga_sync_gen: pixel-tick divider, raster counters and sync/video
// flags delayed to line up with the renderers' registered RGB.
module vga_sync_gen
    import vga_pkg::*;
#(
    parameter int DIV      = DEF_DIV,
    parameter int HD       = DEF_HD,
    parameter int HF       = DEF_HF,
    parameter int HR       = DEF_HR,
    parameter int HB       = DEF_HB,
    parameter int VD       = DEF_VD,
    parameter int VF       = DEF_VF,
    parameter int VR       = DEF_VR,
    parameter int VB       = DEF_VB,
    parameter int SYNC_DLY = DEF_SYNC_DLY
) (
    input  logic       clk,
    input  logic       reset,
    output logic       p_tick,
    output logic [9:0] pix_x,
    output logic [9:0] pix_y,
    output logic       hsync,
    output logic       vsync,
    output logic       video_on,
    output logic       frame_start
);

    localparam int HT = HD + HF + HR + HB;
    localparam int VT = VD + VF + VR + VB;
    localparam int DW = cnt_width(DIV);

    localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
    localparam logic [9:0]    H_VIS    = 10'(HD);
    localparam logic [9:0]    V_VIS    = 10'(VD);
    localparam logic [9:0]    HS_LO    = 10'(HD + HF);
    localparam logic [9:0]    HS_HI    = 10'(HD + HF + HR - 1);
    localparam logic [9:0]    VS_LO    = 10'(VD + VF);
    localparam logic [9:0]    VS_HI    = 10'(VD + VF + VR - 1);

    if (SYNC_DLY < 1 || SYNC_DLY > 8) begin : g_dly_chk
        $error("vga_sync_gen: SYNC_DLY must be 1..8");
    end

    logic [DW-1:0] div_cnt;
    logic          div_wrap_unused;
    logic [9:0]    h_cnt;
    logic [9:0]    v_cnt;
    logic          h_wrap;
    logic          v_wrap;

    logic p_tick_q, p_tick_d;
    logic fs_q, fs_d;

    logic hs_raw, vs_raw, vid_raw;
    logic [SYNC_DLY-1:0] hs_q, vs_q, vid_q;

    mod_n_counter #(.N(DIV), .W(DW)) u_div (
        .clk     (clk),
        .reset   (reset),
        .en_i    (1'b1),
        .count_o (div_cnt),
        .wrap_o  (div_wrap_unused)
    );

    mod_n_counter #(.N(HT), .W(10)) u_hcnt (
        .clk     (clk),
        .reset   (reset),
        .en_i    (p_tick_q),
        .count_o (h_cnt),
        .wrap_o  (h_wrap)
    );

    mod_n_counter #(.N(VT), .W(10)) u_vcnt (
        .clk     (clk),
        .reset   (reset),
        .en_i    (h_wrap),
        .count_o (v_cnt),
        .wrap_o  (v_wrap)
    );

    assign p_tick_d = (div_cnt == DIV_LAST);
    assign fs_d     = h_wrap && v_wrap;

    assign hs_raw  = !((h_cnt >= HS_LO) && (h_cnt <= HS_HI));
    assign vs_raw  = !((v_cnt >= VS_LO) && (v_cnt <= VS_HI));
    assign vid_raw = (h_cnt < H_VIS) && (v_cnt < V_VIS);

    // pixel tick and frame-start strobes, both one clock wide
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            p_tick_q <= 1'b0;
            fs_q     <= 1'b0;
        end else begin
            p_tick_q <= p_tick_d;
            fs_q     <= fs_d;
        end
    end

    // flag delay lines, shifted every clock to match the RGB pipeline
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hs_q  <= '1;
            vs_q  <= '1;
            vid_q <= '0;
        end else begin
            hs_q[0]  <= hs_raw;
            vs_q[0]  <= vs_raw;
            vid_q[0] <= vid_raw;
            for (int i = 1; i < SYNC_DLY; i++) begin
                hs_q[i]  <= hs_q[i-1];
                vs_q[i]  <= vs_q[i-1];
                vid_q[i] <= vid_q[i-1];
            end
        end
    end

    assign p_tick      = p_tick_q;
    assign pix_x       = h_cnt;
    assign pix_y       = v_cnt;
    assign hsync       = hs_q[SYNC_DLY-1];
    assign vsync       = vs_q[SYNC_DLY-1];
    assign video_on    = vid_q[SYNC_DLY-1];
    assign frame_start = fs_q;

endmodule

// File: tb/tb_vga_sync_gen.sv
// tb_vga_sync_gen: default build plus a shrunken SYNC_DLY=1 build,
// both checked every clock against an arithmetic raster model.
module tb_vga_sync_gen;

    localparam int BDIV = 2;
    localparam int BHD = 20, BHF = 3, BHR = 4, BHB = 5;
    localparam int BVD = 6, BVF = 2, BVR = 2, BVB = 3;
    localparam int BHT = BHD + BHF + BHR + BHB;
    localparam int BVT = BVD + BVF + BVR + BVB;
    localparam int BFRAME = BHT * BVT * BDIV;

    logic clk = 1'b0;
    logic rst_a = 1'b0;
    logic rst_b = 1'b0;

    logic       pt_a, hs_a, vs_a, vo_a, fs_a;
    logic [9:0] px_a, py_a;
    logic       pt_b, hs_b, vs_b, vo_b, fs_b;
    logic [9:0] px_b, py_b;

    int errs = 0;
    int checks = 0;
    int ka = 0;
    int kb = 0;

    always #5 clk = ~clk;

    vga_sync_gen u_a (
        .clk         (clk),
        .reset       (rst_a),
        .p_tick      (pt_a),
        .pix_x       (px_a),
        .pix_y       (py_a),
        .hsync       (hs_a),
        .vsync       (vs_a),
        .video_on    (vo_a),
        .frame_start (fs_a)
    );

    vga_sync_gen #(
        .DIV(BDIV), .HD(BHD), .HF(BHF), .HR(BHR), .HB(BHB),
        .VD(BVD), .VF(BVF), .VR(BVR), .VB(BVB), .SYNC_DLY(1)
    ) u_b (
        .clk         (clk),
        .reset       (rst_b),
        .p_tick      (pt_b),
        .pix_x       (px_b),
        .pix_y       (py_b),
        .hsync       (hs_b),
        .vsync       (vs_b),
        .video_on    (vo_b),
        .frame_start (fs_b)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d at t=%0t",
                     tag, got, exp, $time);
        end
    endtask

    // pixels consumed after k clock edges since reset release
    function automatic int n_of(input int k, input int div);
        return (k < 1) ? 0 : (k - 1) / div;
    endfunction

    task automatic model_chk(
        input string nm, input int k, input int div,
        input int hd, input int hf, input int hr, input int hb,
        input int vd, input int vf, input int vr, input int vb,
        input int d, input logic rstn,
        input logic pt, input logic [9:0] px, input logic [9:0] py,
        input logic hs, input logic vs, input logic vo, input logic fs);
        int ht, vt, n, np, nd, xd, yd;
        if (!rstn) begin
            chk({nm, "_rst_ptick"}, pt, 0);
            chk({nm, "_rst_x"}, px, 0);
            chk({nm, "_rst_y"}, py, 0);
            chk({nm, "_rst_hs"}, hs, 1);
            chk({nm, "_rst_vs"}, vs, 1);
            chk({nm, "_rst_vo"}, vo, 0);
            chk({nm, "_rst_fs"}, fs, 0);
        end else begin
            ht = hd + hf + hr + hb;
            vt = vd + vf + vr + vb;
            n  = n_of(k, div);
            np = n_of(k - 1, div);
            chk({nm, "_ptick"}, pt, (k >= div) && (k % div == 0));
            chk({nm, "_x"}, px, n % ht);
            chk({nm, "_y"}, py, (n / ht) % vt);
            chk({nm, "_fs"}, fs,
                (n > 0) && (n % (ht * vt) == 0) && (n != np));
            if (k < d) begin
                chk({nm, "_hs"}, hs, 1);
                chk({nm, "_vs"}, vs, 1);
                chk({nm, "_vo"}, vo, 0);
            end else begin
                nd = n_of(k - d, div);
                xd = nd % ht;
                yd = (nd / ht) % vt;
                chk({nm, "_hs"}, hs,
                    !(xd >= hd + hf && xd < hd + hf + hr));
                chk({nm, "_vs"}, vs,
                    !(yd >= vd + vf && yd < vd + vf + vr));
                chk({nm, "_vo"}, vo, (xd < hd) && (yd < vd));
            end
        end
    endtask

    // edges seen since each reset release
    always @(posedge clk) begin
        ka <= rst_a ? ka + 1 : 0;
        kb <= rst_b ? kb + 1 : 0;
    end

    // per-clock comparison of both builds against the model
    always @(posedge clk) begin
        #2;
        model_chk("A", ka, 4, 640, 16, 96, 48, 480, 10, 2, 33, 3,
                  rst_a, pt_a, px_a, py_a, hs_a, vs_a, vo_a, fs_a);
        model_chk("B", kb, BDIV, BHD, BHF, BHR, BHB,
                  BVD, BVF, BVR, BVB, 1,
                  rst_b, pt_b, px_b, py_b, hs_b, vs_b, vo_b, fs_b);
    end

    int a_cyc = 0, a_wrap_t = 0, a_656_t = 0, a_hs_run = 0;
    bit a_have_wrap = 0, a_have_656 = 0;
    logic [9:0] a_px_prev = 0;
    logic a_hs_prev = 1'b1;

    // default build: line period, hsync width and hsync lag
    always @(posedge clk) begin
        #2;
        a_cyc++;
        if (!rst_a) begin
            a_have_wrap = 0;
            a_have_656  = 0;
            a_hs_run    = 0;
            a_px_prev   = 0;
            a_hs_prev   = 1'b1;
        end else begin
            if (a_px_prev == 799 && px_a == 0) begin
                if (a_have_wrap)
                    chk("A_line_period", a_cyc - a_wrap_t, 3200);
                a_have_wrap = 1;
                a_wrap_t = a_cyc;
            end
            if (a_px_prev == 655 && px_a == 656) begin
                a_have_656 = 1;
                a_656_t = a_cyc;
            end
            if (a_hs_prev && !hs_a && a_have_656)
                chk("A_hs_fall_lag", a_cyc - a_656_t, 3);
            if (!hs_a) begin
                a_hs_run++;
            end else begin
                if (!a_hs_prev && a_hs_run > 0)
                    chk("A_hs_low_len", a_hs_run, 384);
                a_hs_run = 0;
            end
            a_px_prev = px_a;
            a_hs_prev = hs_a;
        end
    end

    int b_per = 0, b_vs = 0, b_vo = 0;
    bit b_have = 0;

    // small build: frame period and per-frame vsync/video totals
    always @(posedge clk) begin
        #2;
        if (!rst_b) begin
            b_have = 0;
            b_per = 0;
            b_vs = 0;
            b_vo = 0;
        end else begin
            b_per++;
            if (!vs_b) b_vs++;
            if (vo_b) b_vo++;
            if (fs_b) begin
                if (b_have) begin
                    chk("B_frame_period", b_per, BFRAME);
                    chk("B_vs_low", b_vs, BVR * BHT * BDIV);
                    chk("B_vo_high", b_vo, BHD * BVD * BDIV);
                end
                b_have = 1;
                b_per = 0;
                b_vs = 0;
                b_vo = 0;
            end
        end
    end

    task automatic rst_pulse(input bit sel, input int hold);
        int off;
        off = 3 + int'($urandom_range(0, 5));
        if (off == 5) off = 6;
        @(posedge clk);
        #(off);
        if (sel) rst_b = 1'b0;
        else     rst_a = 1'b0;
        #1;
        if (sel) begin
            chk("B_async_hs", hs_b, 1);
            chk("B_async_x", px_b, 0);
            chk("B_async_vo", vo_b, 0);
        end else begin
            chk("A_async_hs", hs_a, 1);
            chk("A_async_x", px_a, 0);
            chk("A_async_vo", vo_a, 0);
        end
        repeat (hold) @(posedge clk);
        @(negedge clk);
        if (sel) rst_b = 1'b1;
        else     rst_a = 1'b1;
    endtask

    initial begin
        fork
            begin
                int w;
                repeat (5) @(posedge clk);
                @(negedge clk) rst_a = 1'b1;
                w = 0;
                @(posedge clk);
                #2;
                while (px_a != 10'd700 && w < 4000) begin
                    @(posedge clk);
                    #2;
                    w++;
                end
                chk("A_wait700", w < 4000, 1);
                chk("A_pre_hs", hs_a, 0);
                #1 rst_a = 1'b0;
                #1;
                chk("A_mid_hs", hs_a, 1);
                chk("A_mid_vs", vs_a, 1);
                chk("A_mid_x", px_a, 0);
                chk("A_mid_y", py_a, 0);
                chk("A_mid_fs", fs_a, 0);
                repeat (3) @(posedge clk);
                @(negedge clk) rst_a = 1'b1;
                repeat (7000) @(posedge clk);
                repeat (8) begin
                    repeat ($urandom_range(50, 3500)) @(posedge clk);
                    rst_pulse(1'b0, int'($urandom_range(1, 6)));
                end
                repeat (100) @(posedge clk);
            end
            begin
                repeat (3) @(posedge clk);
                @(negedge clk) rst_b = 1'b1;
                repeat (4 * BFRAME + 50) @(posedge clk);
                repeat (10) begin
                    repeat ($urandom_range(20, 1500)) @(posedge clk);
                    rst_pulse(1'b1, int'($urandom_range(1, 6)));
                end
                repeat (100) @(posedge clk);
            end
        join
        @(posedge clk);
        #3;
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/vga_sync_gen.md
# vga_sync_gen

Raster timing generator for the 640x480@60 Hz VGA display path on the Artix-7 board. It divides the 100 MHz system clock into a 25 MHz pixel-tick enable and runs the horizontal and vertical position counters. It drives `pix_x`/`pix_y` to the symbol and digit renderers. It also produces `hsync`, `vsync` and `video_on`, delayed so they stay aligned with the renderers' registered 12-bit RGB output.

## Interface
Parameters:
- `DIV`, 4: system clocks per pixel.
- `HD`, 640: visible pixels per line.
- `HF`, 16: horizontal front porch.
- `HR`, 96: horizontal sync width.
- `HB`, 48: horizontal back porch.
- `VD`, 480: visible lines.
- `VF`, 10: vertical front porch.
- `VR`, 2: vertical sync width.
- `VB`, 33: vertical back porch.
- `SYNC_DLY`, 3: clock-cycle delay on `hsync`/`vsync`/`video_on`; legal range 1..8.

Ports:
- `clk`  in  1  system clock, 100 MHz.
- `reset`  in  1  asynchronous, active-low reset. One clock; reset is asynchronous and active-low.
- `p_tick`  out  1  pixel enable; one `clk` wide, every `DIV` clocks.
- `pix_x`  out  10  horizontal count, 0..H_TOTAL-1; undelayed.
- `pix_y`  out  10  vertical count, 0..V_TOTAL-1; undelayed.
- `hsync`  out  1  horizontal sync, active low, delayed.
- `vsync`  out  1  vertical sync, active low, delayed.
- `video_on`  out  1  visible-area flag, delayed.
- `frame_start`  out  1  one-clock pulse when counters enter (0,0).

## Operation
- H_TOTAL = HD+HF+HR+HB = 800. V_TOTAL = VD+VF+VR+VB = 525.
- Divider `div_cnt` runs 0..DIV-1 and wraps. `p_tick` is a registered flag: 1 in the cycle after `div_cnt` == DIV-1.
- On `p_tick`:
  - `h_cnt` increments.
  - At H_TOTAL-1 it wraps to 0, and `v_cnt` increments.
  - At V_TOTAL-1, `v_cnt` wraps to 0.
- Counters are unsigned 10 bit and never reach 1023.
- `pix_x` = `h_cnt`, `pix_y` = `v_cnt`, both registered and changing only on `p_tick` edges.
- Raw flags, combinational from the counters:
  - hsync_raw = 0 iff HD+HF ≤ h_cnt ≤ HD+HF+HR-1, i.e. 656..751.
  - vsync_raw = 0 iff VD+VF ≤ v_cnt ≤ VD+VF+VR-1, i.e. 490..491.
  - video_raw = (h_cnt < HD) && (v_cnt < VD).
- Delay line: each raw flag passes through a `SYNC_DLY`-stage shift register clocked every `clk`, not gated by `p_tick`. Outputs are the last stage.
- `frame_start`: registered. It is 1 for exactly one clock, in the cycle where `h_cnt` and `v_cnt` first read (0,0) after a wrap. It is not asserted on reset release.

## Timing
- Reset values while `reset`=0:
  - `div_cnt`=0, `h_cnt`=0, `v_cnt`=0.
  - `p_tick`=0, `frame_start`=0.
  - Every `hsync`/`vsync` stage =1 and every `video_on` stage =0, including the outputs.
- Reset assertion takes effect immediately; no clock is needed.
- Mid-frame reset: outputs go to reset values at once. After release the frame restarts at (0,0) with no glitch pulse on sync.
- First `p_tick`: in the DIV-th clock after reset release, i.e. clock 4 by default.
- Counter latency: `pix_x` updates on the clock edge that samples `p_tick`=1.
- Delayed-output latency: `hsync`, `vsync` and `video_on` lag the counter change that caused them by exactly `SYNC_DLY` clocks. The default 3 matches the renderer's Selector → Adress/Numero → COLOR_IN pipeline.
- Counter periods:
  - Line: 800 pixels = 3200 clocks.
  - Frame: 525 lines = 1,680,000 clocks.
- Wrap coincidence: when `h_cnt` and `v_cnt` wrap on the same `p_tick`, both become 0 on that edge, and `frame_start` fires on that edge.

## Structure
- Shared package `vga_pkg`:
  - default timing constants HD/HF/HR/HB/VD/VF/VR/VB.
  - derived H_TOTAL/V_TOTAL and the sync start/end positions.
  - 12-bit RGB color type shared with the renderers.
- One sub-module, `mod_n_counter`:
  - parameters: N, width.
  - inputs: enable.
  - outputs: count, wrap flag.
  - instantiated three times: divider, horizontal counter, vertical counter (vertical enable = `p_tick` && h wrap).
- Delay lines stay inline as generate-sized shift registers.

## Test plan
- Reset release, `reset` held low for 5 clocks and then driven high → all outputs hold reset values while low. First `p_tick` arrives at clock 4 after release; `pix_x` reads 1 at clock 5.
- Full line → `pix_x` counts 0..799 and wraps to 0 exactly 3200 clocks after the previous wrap. `hsync` is low for 96×4 = 384 clocks. Its falling edge comes 3 clocks after `pix_x` becomes 656.
- Full frame → `vsync` is low for exactly 2 lines (6400 clocks) at `pix_y` 490..491. `frame_start` pulses once per 1,680,000 clocks. `video_on` is high for 640×480×4 clocks total.
- Visible boundary → `video_on` falls 3 clocks after `pix_x` goes 639→640. It rises 3 clocks after `pix_x` goes 799→0 on lines 0..479. It stays low throughout lines 480..524.
- Async reset at `pix_x`=700, `pix_y`=300 (inside hsync) → `hsync` returns to 1 with no clock edge. Counters read 0, and there is no `frame_start` after release.
- `SYNC_DLY`=1 build → `hsync` falling edge is 1 clock after `pix_x`=656. Counter behaviour is unchanged.
